matmul_req_sequencer: RTL and testbench
=======================================

// Module: matmul_req_sequencer
// PURPOSE
//  Sequences the 4x4x16-bit matrix multiplication unit and shares it between NUM_REQ requesters.
//  Each request carries an A/B operand pair (256 b each); the block selects a requester round-robin
//  and drives the unit's enable/RW/data handshake: load A, load B, then read the product.
//  It returns the product with the requester ID. Sits between the execution-engine ports and the multiplier.
// PARAMETERS
//  NUM_REQ   2    number of requesters (1..4)
//  TIMEOUT   16   max cycles to wait for mm_flag in WAIT_A/WAIT_B before aborting (>=2)
// PORTS
//  clk          in   1            single clock, all logic on posedge
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NUM_REQ      per-requester request valid
//  req_ready    out  NUM_REQ      one-hot accept strobe; at most one bit high per cycle
//  req_mat_a    in   NUM_REQ*256  operand A; requester r occupies bits [r*256+:256]
//  req_mat_b    in   NUM_REQ*256  operand B, same packing; element [i][j] at bits [i*64+16*j+:16]
//  rsp_valid    out  1            response valid; held until rsp_ready
//  rsp_ready    in   1            response consumer ready
//  rsp_data     out  256          product matrix, same element packing
//  rsp_id       out  2            index of the requester served
//  rsp_err      out  1            1 = timeout abort; rsp_data is then 0
//  mm_enable    out  1            multiplier enable
//  mm_rw        out  1            multiplier RW (1 = load operand, 0 = read result)
//  mm_data_in   out  256          multiplier operand bus
//  mm_data_out  in   256          multiplier result bus
//  mm_flag      in   1            multiplier flag
//  busy         out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; round-robin pointer = 0. Asserting rst_n low mid-sequence aborts
//  the sequence at once and emits no response; the requester must re-request.
//  FSM (one state per cycle unless stated otherwise):
//   IDLE    - if any req_valid: pick the first valid at or after the pointer (round-robin).
//             Pulse req_ready[g] for 1 cycle; latch A, B and g; pointer <= g+1 mod NUM_REQ; go to LOAD_A.
//   LOAD_A  - mm_enable=1, mm_rw=1, mm_data_in=A; clear the timeout counter; go to WAIT_A.
//   WAIT_A  - mm_enable=0. If mm_flag==1, go to LOAD_B.
//             Otherwise increment the counter; when it reaches TIMEOUT, go to RESP with err=1.
//   LOAD_B  - mm_enable=1, mm_rw=1, mm_data_in=B; clear the counter; go to WAIT_B.
//   WAIT_B  - same rules as WAIT_A; on success go to READ.
//   READ    - mm_enable=1, mm_rw=0; go to CAPTURE.
//   CAPTURE - mm_enable=0; register mm_data_out into rsp_data; go to RESP.
//   RESP    - rsp_valid=1, with rsp_data, rsp_id and rsp_err stable.
//             When rsp_ready is high, drop rsp_valid the next cycle and go to IDLE.
//  mm_enable is a 1-cycle pulse only, in LOAD_A, LOAD_B and READ; it is never high in consecutive cycles.
//  mm_data_in holds its last value while mm_enable is low.
//  Latency: accept (req_ready) at cycle 0, rsp_valid at cycle 7 when mm_flag answers the next cycle
//  and rsp_ready is high. Throughput is therefore one request per 8 cycles.
//  New requests are not sampled outside IDLE; req_valid may stay high while waiting.
//  A request raised in the same cycle the FSM leaves RESP is seen in the next IDLE cycle.
//  Simultaneous req_valid: the round-robin pick is strictly fair; a lone requester is served back-to-back.
//  On timeout, rsp_err=1 and rsp_data=0; the multiplier is not read.
//  rsp_id is zero-extended when NUM_REQ < 4.
// STRUCTURE
//  Package matmul_pkg: MAT_W=256, ELEM_W=16, MAT_DIM=4, and the FSM state enum
//   (IDLE, LOAD_A, WAIT_A, LOAD_B, WAIT_B, READ, CAPTURE, RESP).
//  Sub-module rr_arbiter #(N): inputs req[N], update, ptr register; outputs one-hot gnt and index.
//  The FSM, operand latches and timeout counter live in the top module.
// TESTING (bench includes a behavioural multiplier model that asserts flag the cycle after each load)
//  1. Requester 0: A=identity (diagonal 16'h0001), B[i][j]=i*4+j
//     -> rsp_data==B, rsp_id=0, rsp_err=0, rsp_valid exactly 7 cycles after req_ready[0].
//  2. Both requesters valid continuously for 4 requests -> grant order 0,1,0,1; every response carries the correct ID and product.
//  3. Model holds mm_flag=0 after LOAD_A, TIMEOUT=16
//     -> rsp_err=1 and rsp_data=0 after 16 WAIT_A cycles; no LOAD_B or READ pulse occurs.
//  4. rsp_ready held low for 10 cycles -> rsp_valid/data/id stay stable, no new req_ready, then IDLE one cycle after the handshake.
//  5. rst_n driven low during WAIT_B -> all outputs 0 immediately (async); after release, a fresh request completes normally.
//  6. Assertion across all tests: mm_enable never high in two consecutive cycles; popcount(req_ready)<=1.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and FSM state type for the matrix-multiply request sequencer.
package matmul_pkg;

   localparam int unsigned ELEM_W  = 16;
   localparam int unsigned MAT_DIM = 4;
   localparam int unsigned MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StWaitA,
      StLoadB,
      StWaitB,
      StRead,
      StCapture,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// advances the pointer past the winner when i_update is high.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_req,
   input  logic         i_update,
   output logic [N-1:0] o_gnt,
   output logic [1:0]   o_idx
);

   logic [1:0]   r_ptr;
   logic [N-1:0] w_rot;
   logic [2:0]   w_off;
   logic [2:0]   w_sum;
   logic [2:0]   w_win;
   logic         w_found;

   // Rotate requests so the pointer sits at bit 0, find the first set bit, map it back.
   always_comb begin
      w_rot   = N'({i_req, i_req} >> r_ptr);
      w_off   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = 3'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + w_off;
      w_win = (w_sum >= 3'(N)) ? w_sum - 3'(N) : w_sum;
   end

   assign o_gnt = w_found ? (N'(1) << w_win) : '0;
   assign o_idx = w_win[1:0];

   // Pointer moves to the requester after the winner so every requester gets its turn.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_update && w_found) begin
         r_ptr <= (w_win == 3'(N - 1)) ? 2'd0 : w_win[1:0] + 2'd1;
      end
   end

endmodule

// File: rtl/matmul_req_sequencer.sv
// Shares the 4x4x16 multiplier between NUM_REQ requesters: load A, load B, read
// the product, and return it tagged with the requester index.
module matmul_req_sequencer
   import matmul_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*MAT_W-1:0] i_req_mat_a,
   input  logic [NUM_REQ*MAT_W-1:0] i_req_mat_b,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [MAT_W-1:0]         o_rsp_data,
   output logic [1:0]               o_rsp_id,
   output logic                     o_rsp_err,
   output logic                     o_mm_enable,
   output logic                     o_mm_rw,
   output logic [MAT_W-1:0]         o_mm_data_in,
   input  logic [MAT_W-1:0]         i_mm_data_out,
   input  logic                     i_mm_flag,
   output logic                     o_busy
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   state_e              r_state;
   logic [CntW-1:0]     r_cnt;
   logic [MAT_W-1:0]    r_mat_b;
   logic [1:0]          r_id;
   logic                r_mm_enable;
   logic                r_mm_rw;
   logic [MAT_W-1:0]    r_mm_data_in;
   logic                r_rsp_valid;
   logic [MAT_W-1:0]    r_rsp_data;
   logic [1:0]          r_rsp_id;
   logic                r_rsp_err;

   logic                w_idle;
   logic                w_any;
   logic                w_timeout;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [1:0]          w_idx;
   logic [MAT_W-1:0]    w_sel_a;
   logic [MAT_W-1:0]    w_sel_b;

   assign w_idle    = (r_state == StIdle);
   assign w_any     = |i_req_valid;
   assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1));
   assign w_sel_a   = i_req_mat_a[MAT_W*w_idx +: MAT_W];
   assign w_sel_b   = i_req_mat_b[MAT_W*w_idx +: MAT_W];

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    (i_req_valid),
      .i_update (w_idle),
      .o_gnt    (w_gnt),
      .o_idx    (w_idx)
   );

   // The accept strobe is combinational in IDLE; rst_n gating keeps it low while reset is held.
   assign o_req_ready  = (w_idle && i_rst_n) ? w_gnt : '0;
   assign o_busy       = !w_idle;
   assign o_mm_enable  = r_mm_enable;
   assign o_mm_rw      = r_mm_rw;
   assign o_mm_data_in = r_mm_data_in;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_err    = r_rsp_err;

   // Sequencer FSM; outputs are set on entry to the state that owns them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_mat_b      <= '0;
         r_id         <= '0;
         r_mm_enable  <= 1'b0;
         r_mm_rw      <= 1'b0;
         r_mm_data_in <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_id     <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_mm_data_in <= w_sel_a;
                  r_mat_b      <= w_sel_b;
                  r_id         <= w_idx;
                  r_mm_enable  <= 1'b1;
                  r_mm_rw      <= 1'b1;
                  r_state      <= StLoadA;
               end
            end
            StLoadA: begin
               r_mm_enable <= 1'b0;
               r_cnt       <= '0;
               r_state     <= StWaitA;
            end
            StWaitA: begin
               if (i_mm_flag) begin
                  r_mm_enable  <= 1'b1;
                  r_mm_rw      <= 1'b1;
                  r_mm_data_in <= r_mat_b;
                  r_state      <= StLoadB;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_id    <= r_id;
                  r_state     <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StLoadB: begin
               r_mm_enable <= 1'b0;
               r_cnt       <= '0;
               r_state     <= StWaitB;
            end
            StWaitB: begin
               if (i_mm_flag) begin
                  r_mm_enable <= 1'b1;
                  r_mm_rw     <= 1'b0;
                  r_state     <= StRead;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_id    <= r_id;
                  r_state     <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StRead: begin
               r_mm_enable <= 1'b0;
               r_state     <= StCapture;
            end
            StCapture: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= i_mm_data_out;
               r_rsp_id    <= r_id;
               r_state     <= StResp;
            end
            StResp: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_req_sequencer.sv
// Randomised bench with a transaction-level reference model and a multiplier model.
module tb_matmul_req_sequencer;
   import matmul_pkg::*;

   localparam int unsigned NR = 2;
   localparam int unsigned TO = 16;
   localparam int ROW_W = MAT_DIM * ELEM_W;

   logic                clk;
   logic                rst_n;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [NR*MAT_W-1:0] req_mat_a;
   logic [NR*MAT_W-1:0] req_mat_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [MAT_W-1:0]    rsp_data;
   logic [1:0]          rsp_id;
   logic                rsp_err;
   logic                mm_enable;
   logic                mm_rw;
   logic [MAT_W-1:0]    mm_data_in;
   logic [MAT_W-1:0]    mm_data_out;
   logic                mm_flag;
   logic                busy;

   matmul_req_sequencer #(
      .NUM_REQ (NR),
      .TIMEOUT (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_mat_a   (req_mat_a),
      .i_req_mat_b   (req_mat_b),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_data    (rsp_data),
      .o_rsp_id      (rsp_id),
      .o_rsp_err     (rsp_err),
      .o_mm_enable   (mm_enable),
      .o_mm_rw       (mm_rw),
      .o_mm_data_in  (mm_data_in),
      .i_mm_data_out (mm_data_out),
      .i_mm_flag     (mm_flag),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [MAT_W-1:0] mat_mul(input logic [MAT_W-1:0] a,
                                                input logic [MAT_W-1:0] b);
      logic [MAT_W-1:0]  p;
      logic [ELEM_W-1:0] acc;
      logic [ELEM_W-1:0] ea;
      logic [ELEM_W-1:0] eb;
      p = '0;
      for (int i = 0; i < MAT_DIM; i++) begin
         for (int j = 0; j < MAT_DIM; j++) begin
            acc = '0;
            for (int k = 0; k < MAT_DIM; k++) begin
               ea  = a[i*ROW_W + k*ELEM_W +: ELEM_W];
               eb  = b[k*ROW_W + j*ELEM_W +: ELEM_W];
               acc = acc + ea * eb;
            end
            p[i*ROW_W + j*ELEM_W +: ELEM_W] = acc;
         end
      end
      return p;
   endfunction

   task automatic chk(input string name, input logic [MAT_W-1:0] act,
                      input logic [MAT_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Multiplier model: first load is A, second is B, flag the cycle after each accepted load.
   // hold_flag makes it ignore loads entirely so the sequencer times out.
   logic [MAT_W-1:0] mm_a;
   logic [MAT_W-1:0] mm_b;
   bit               ld_sel;
   bit               hold_flag;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_flag <= 1'b0;
         ld_sel  <= 1'b0;
         mm_a    <= '0;
         mm_b    <= '0;
      end else begin
         mm_flag <= mm_enable && mm_rw && !hold_flag;
         if (mm_enable && mm_rw && !hold_flag) begin
            if (!ld_sel) mm_a <= mm_data_in;
            else         mm_b <= mm_data_in;
            ld_sel <= !ld_sel;
         end
      end
   end

   assign mm_data_out = mat_mul(mm_a, mm_b);

   // Reference model state: one transaction at a time, timed from its accept cycle.
   bit               m_busy = 1'b0;
   int               m_t0;
   bit               m_err;
   int               m_ptr = 0;
   logic [1:0]       m_id;
   logic [MAT_W-1:0] m_a;
   logic [MAT_W-1:0] m_b;
   logic [MAT_W-1:0] m_prod;
   bit               prev_en = 1'b0;
   bit               prev_rv = 1'b0;
   int               acc_cnt = 0;
   int               rsp_cnt = 0;
   int               rsp_lat = -1;
   int               en_cnt = 0;
   int               acc_ids[$];
   logic [MAT_W-1:0] rsp_dat;
   logic [1:0]       rsp_id_s;
   logic             rsp_err_s;

   always @(negedge clk) begin : compare
      int            g;
      int            d;
      int            k_idx;
      logic [NR-1:0] exp_rdy;
      bit            exp_en;
      bit            exp_v;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, '0);
         chk("rst_rsp_valid", rsp_valid, '0);
         chk("rst_rsp_data", rsp_data, '0);
         chk("rst_mm_enable", mm_enable, '0);
         chk("rst_mm_data_in", mm_data_in, '0);
         chk("rst_busy", busy, '0);
         m_busy  = 1'b0;
         m_ptr   = 0;
         prev_en = 1'b0;
         prev_rv = 1'b0;
      end else begin
         chk("enable_back_to_back", prev_en && mm_enable, '0);
         chk("ready_onehot", ($countones(req_ready) <= 1), 1);
         if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
               k_idx = (m_ptr + k) % NR;
               if (g < 0 && req_valid[k_idx]) g = k_idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("idle_busy", busy, '0);
            chk("idle_rsp_valid", rsp_valid, '0);
            chk("idle_mm_enable", mm_enable, '0);
            if (g >= 0) begin
               m_busy = 1'b1;
               m_t0   = cyc;
               m_err  = hold_flag;
               m_id   = 2'(g);
               m_a    = req_mat_a[g*MAT_W +: MAT_W];
               m_b    = req_mat_b[g*MAT_W +: MAT_W];
               m_prod = m_err ? '0 : mat_mul(m_a, m_b);
               m_ptr  = (g + 1) % NR;
               acc_cnt++;
               acc_ids.push_back(g);
               en_cnt = 0;
            end
         end else begin
            d      = cyc - m_t0;
            exp_en = (d == 1) || (!m_err && (d == 3 || d == 5));
            chk("busy_req_ready", req_ready, '0);
            chk("busy", busy, 1);
            chk("mm_enable", mm_enable, exp_en);
            if (mm_enable) en_cnt++;
            if (d == 1) begin
               chk("load_a_rw", mm_rw, 1);
               chk("load_a_data", mm_data_in, m_a);
            end
            if (!m_err && d == 3) begin
               chk("load_b_rw", mm_rw, 1);
               chk("load_b_data", mm_data_in, m_b);
            end
            if (!m_err && d == 5) chk("read_rw", mm_rw, 0);
            exp_v = d >= (m_err ? TO + 2 : 7);
            chk("rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && !prev_rv) begin
               rsp_cnt++;
               rsp_lat   = d;
               rsp_dat   = rsp_data;
               rsp_id_s  = rsp_id;
               rsp_err_s = rsp_err;
            end
            if (exp_v) begin
               chk("rsp_data", rsp_data, m_prod);
               chk("rsp_id", rsp_id, m_id);
               chk("rsp_err", rsp_err, m_err);
               if (rsp_ready) m_busy = 1'b0;
            end
         end
         prev_en = mm_enable;
         prev_rv = rsp_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int base, input string name);
      int n = 0;
      while (acc_cnt <= base && n < 60) begin
         tick();
         n++;
      end
      chk(name, acc_cnt > base, 1);
   endtask

   task automatic wait_rsp(input int base, input string name);
      int n = 0;
      while (rsp_cnt <= base && n < 60) begin
         tick();
         n++;
      end
      chk(name, rsp_cnt > base, 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (m_busy && n < 200) begin
         tick();
         n++;
      end
      chk(name, m_busy, 0);
   endtask

   task automatic rand_ops(input int r);
      for (int w = 0; w < MAT_W / 32; w++) begin
         req_mat_a[r*MAT_W + w*32 +: 32] = $urandom;
         req_mat_b[r*MAT_W + w*32 +: 32] = $urandom;
      end
   endtask

   logic [MAT_W-1:0] ident;
   logic [MAT_W-1:0] bseq;
   int               base;
   int               rbase;

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      req_mat_a = '0;
      req_mat_b = '0;
      rsp_ready = 1'b1;
      hold_flag = 1'b0;
      ident     = '0;
      bseq      = '0;
      for (int i = 0; i < MAT_DIM; i++) begin
         ident[i*ROW_W + i*ELEM_W +: ELEM_W] = 16'h0001;
         for (int j = 0; j < MAT_DIM; j++) bseq[i*ROW_W + j*ELEM_W +: ELEM_W] = 16'(i*4 + j);
      end
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Identity times B returns B after exactly 7 cycles.
      req_mat_a[0 +: MAT_W] = ident;
      req_mat_b[0 +: MAT_W] = bseq;
      req_valid = 2'b01;
      base = acc_cnt;
      wait_acc(base, "t1_accept");
      req_valid = '0;
      wait_idle("t1_idle");
      chk("t1_latency", rsp_lat, 7);
      chk("t1_data", rsp_dat, bseq);
      chk("t1_id", rsp_id_s, 0);
      chk("t1_err", rsp_err_s, 0);

      // Fresh pointer, both requesters valid: grants alternate 0,1,0,1.
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rand_ops(0);
      rand_ops(1);
      req_valid = 2'b11;
      base = acc_cnt;
      for (int n = 0; n < 100 && acc_cnt < base + 4; n++) tick();
      req_valid = '0;
      chk("t2_accept_count", acc_cnt, base + 4);
      wait_idle("t2_idle");
      for (int i = 0; i < 4; i++) chk("t2_grant_order", acc_ids[base + i], i % 2);

      // Multiplier never answers: timeout after 16 WAIT_A cycles, single enable pulse.
      hold_flag = 1'b1;
      rand_ops(0);
      req_valid = 2'b01;
      base = acc_cnt;
      wait_acc(base, "t3_accept");
      req_valid = '0;
      wait_idle("t3_idle");
      hold_flag = 1'b0;
      chk("t3_latency", rsp_lat, TO + 2);
      chk("t3_err", rsp_err_s, 1);
      chk("t3_data", rsp_dat, '0);
      chk("t3_id", rsp_id_s, 0);
      chk("t3_enable_pulses", en_cnt, 1);

      // Consumer stalls for 10 cycles while requester 0 waits.
      rand_ops(0);
      rand_ops(1);
      rsp_ready = 1'b0;
      req_valid = 2'b10;
      base  = acc_cnt;
      rbase = rsp_cnt;
      wait_acc(base, "t4_accept");
      req_valid = 2'b01;
      wait_rsp(rbase, "t4_rsp");
      repeat (10) tick();
      chk("t4_no_accept_in_stall", acc_cnt, base + 1);
      chk("t4_id", rsp_id_s, 1);
      rsp_ready = 1'b1;
      wait_acc(base + 1, "t4_next_accept");
      req_valid = '0;
      chk("t4_next_id", acc_ids[$], 0);
      wait_idle("t4_idle");

      // Asynchronous reset in WAIT_B aborts silently; the held request is then served.
      rand_ops(0);
      req_valid = 2'b01;
      base = acc_cnt;
      wait_acc(base, "t5_accept");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_mm_enable", mm_enable, 0);
      chk("t5_mm_data_in", mm_data_in, '0);
      chk("t5_req_ready", req_ready, '0);
      chk("t5_rsp_valid", rsp_valid, 0);
      tick();
      rst_n = 1'b1;
      base = acc_cnt;
      wait_acc(base, "t5_fresh_accept");
      req_valid = '0;
      wait_idle("t5_idle");
      chk("t5_latency", rsp_lat, 7);
      chk("t5_err", rsp_err_s, 0);

      // Random traffic and back-pressure.
      for (int n = 0; n < 400; n++) begin
         tick();
         req_valid = NR'($urandom);
         rand_ops(0);
         rand_ops(1);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("rand_idle");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
